// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU: opcodes, FSM states and flag bit positions.
package alu_pkg;

    typedef enum logic [3:0] {
        OpAdd = 4'd0,
        OpSub = 4'd1,
        OpNot = 4'd2,
        OpAnd = 4'd3,
        OpOr  = 4'd4,
        OpXor = 4'd5,
        OpSlt = 4'd6,
        OpEq  = 4'd7,
        OpMul = 4'd8,
        OpShl = 4'd9,
        OpSrl = 4'd10,
        OpSra = 4'd11
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StMul,
        StDone
    } state_e;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 2;
    localparam int unsigned FLAG_N = 3;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles after start.
module alu_mul_iter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] prod_lo,
    output logic             prod_hi_nz
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [2*WIDTH-1:0] prod_d;
    logic [WIDTH:0]     sum;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;

    // Upper half accumulates the multiplicand; lower half starts as the multiplier and drains out.
    always_comb begin
        sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_d = {sum, prod_q[WIDTH-1:1]};
    end

    // Outputs expose the post-iteration value so the caller can register it on the final edge.
    assign done       = busy_q && (cnt_q == CW'(WIDTH - 1));
    assign prod_lo    = prod_d[WIDTH-1:0];
    assign prod_hi_nz = |prod_d[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else if (start) begin
            mcand_q <= a;
            prod_q  <= {{WIDTH{1'b0}}, b};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else if (busy_q) begin
            prod_q <= prod_d;
            cnt_q  <= cnt_q + CW'(1);
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle logic/arith/shift ops, iterative multiply, Z/C/V/N flags.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam int unsigned SHW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    op_e              op_q;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;

    logic             accept;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_lo;
    logic             mul_hi_nz;

    assign accept    = in_valid && in_ready;
    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign flags     = flags_q;

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_d   = state_q;
        mul_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (op == OpMul) begin
                        state_d   = StMul;
                        mul_start = 1'b1;
                    end else begin
                        state_d = StExec;
                    end
                end
            end
            StExec: state_d = StDone;
            StMul: begin
                if (mul_done) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- operand latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= OpAdd;
        end else if (accept) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= op_e'(op);
        end
    end

    // ---------------------------------------------------------------- multiplier
    alu_mul_iter #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (mul_start),
        .a          (a),
        .b          (b),
        .done       (mul_done),
        .prod_lo    (mul_lo),
        .prod_hi_nz (mul_hi_nz)
    );

    // ---------------------------------------------------------------- single-cycle op unit
    logic [WIDTH-1:0]        b_eff;
    logic [WIDTH:0]          add_sum;
    logic [SHW-1:0]          amt;
    logic [WIDTH:0]          shl_wide;
    logic [WIDTH:0]          srl_wide;
    logic signed [WIDTH:0]   sra_in;
    logic [WIDTH:0]          sra_wide;
    logic [WIDTH-1:0]        exec_res;
    logic                    exec_c;
    logic                    exec_v;

    // Shifts carry an extra bit on the outgoing side so it holds the last bit shifted out.
    always_comb begin
        b_eff    = (op_q == OpSub) ? ~b_q : b_q;
        add_sum  = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (op_q == OpSub)};
        amt      = b_q[SHW-1:0];
        shl_wide = {1'b0, a_q} << amt;
        srl_wide = {a_q, 1'b0} >> amt;
        sra_in   = {a_q, 1'b0};
        sra_wide = sra_in >>> amt;

        exec_res = '0;
        exec_c   = 1'b0;
        exec_v   = 1'b0;
        case (op_q)
            OpAdd, OpSub: begin
                exec_res = add_sum[WIDTH-1:0];
                exec_c   = add_sum[WIDTH];
                exec_v   = (a_q[WIDTH-1] == b_eff[WIDTH-1]) &&
                           (add_sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OpNot: exec_res = ~a_q;
            OpAnd: exec_res = a_q & b_q;
            OpOr:  exec_res = a_q | b_q;
            OpXor: exec_res = a_q ^ b_q;
            OpSlt: exec_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            OpEq:  exec_res = {{(WIDTH-1){1'b0}}, (a_q == b_q)};
            OpShl: begin
                exec_res = shl_wide[WIDTH-1:0];
                exec_c   = shl_wide[WIDTH];
            end
            OpSrl: begin
                exec_res = srl_wide[WIDTH:1];
                exec_c   = srl_wide[0];
            end
            OpSra: begin
                exec_res = sra_wide[WIDTH:1];
                exec_c   = sra_wide[0];
            end
            default: begin
                exec_res = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------- result / flag registers
    logic [WIDTH-1:0] res_sel;
    logic             c_sel;
    logic             v_sel;

    always_comb begin
        result_d = result_q;
        flags_d  = flags_q;
        res_sel  = exec_res;
        c_sel    = exec_c;
        v_sel    = exec_v;
        if (state_q == StMul) begin
            res_sel = mul_lo;
            c_sel   = mul_hi_nz;
            v_sel   = 1'b0;
        end
        if ((state_q == StExec) || ((state_q == StMul) && mul_done)) begin
            result_d        = res_sel;
            flags_d[FLAG_Z] = (res_sel == '0);
            flags_d[FLAG_C] = c_sel;
            flags_d[FLAG_V] = v_sel;
            flags_d[FLAG_N] = res_sel[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=8: directed vectors, random ops, backpressure and reset abort.
module tb_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   flags;

    always #5 clk = ~clk;

    alu_seq #(
        .WIDTH(W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    typedef struct packed {
        logic [3:0] flg;
        logic [7:0] res;
        logic [7:0] lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: returns {flags N,V,C,Z, result}.
    function automatic logic [11:0] model(input logic [3:0] o, input logic [7:0] xa,
                                          input logic [7:0] xb);
        int ua, ub, sa, sb, full, n, t;
        logic [7:0] r;
        logic c, v;
        ua = int'(xa);
        ub = int'(xb);
        sa = int'($signed(xa));
        sb = int'($signed(xb));
        n  = int'(xb[2:0]);
        r  = 8'h00;
        c  = 1'b0;
        v  = 1'b0;
        case (o)
            4'd0: begin
                full = ua + ub; r = full[7:0]; c = full[8];
                v = (sa + sb > 127) || (sa + sb < -128);
            end
            4'd1: begin
                full = ua + (255 - ub) + 1; r = full[7:0]; c = full[8];
                v = (sa - sb > 127) || (sa - sb < -128);
            end
            4'd2: r = ~xa;
            4'd3: r = xa & xb;
            4'd4: r = xa | xb;
            4'd5: r = xa ^ xb;
            4'd6: r = (sa < sb) ? 8'd1 : 8'd0;
            4'd7: r = (xa == xb) ? 8'd1 : 8'd0;
            4'd8: begin
                full = ua * ub; r = full[7:0]; c = (full > 255);
            end
            4'd9: begin
                full = ua << n; r = full[7:0]; c = full[8];
            end
            4'd10: begin
                full = ua >> n; r = full[7:0];
                if (n != 0) begin t = ua >> (n - 1); c = t[0]; end
            end
            4'd11: begin
                full = sa >>> n; r = full[7:0];
                if (n != 0) begin t = sa >>> (n - 1); c = t[0]; end
            end
            default: r = 8'h00;
        endcase
        return {r[7], v, c, (r == 8'h00), r};
    endfunction

    // Drive one transaction, check it on completion, optionally stall the consumer.
    task automatic do_op(input logic [3:0] o, input logic [7:0] xa, input logic [7:0] xb,
                         input logic [3:0] ef, input logic [7:0] er, input int hold,
                         input bit pulse);
        exp_t       e;
        int         c;
        logic [7:0] r0;
        logic [3:0] f0;
        sb_q.push_back('{flg: ef, res: er, lat: (o == 4'd8) ? 8'd9 : 8'd2});
        @(negedge clk);
        in_valid = 1'b1; op = o; a = xa; b = xb;
        c = 0;
        while (!in_ready && c < 50) begin @(negedge clk); c++; end
        if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0; op = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
        c = 1;
        while (!out_valid && c < 40) begin @(negedge clk); c++; end
        e = sb_q.pop_front();
        check($sformatf("op%0d_res", o), 32'(result), 32'(e.res));
        check($sformatf("op%0d_flags", o), 32'(flags), 32'(e.flg));
        check($sformatf("op%0d_latency", o), 32'(c), 32'(e.lat));
        check($sformatf("op%0d_in_ready_busy", o), 32'(in_ready), 32'd0);
        r0 = result;
        f0 = flags;
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                in_valid = pulse && (i == 1);
                op = 4'd0;
                @(negedge clk);
            end
            in_valid = 1'b0;
            check("bp_res_stable", 32'(result), 32'(r0));
            check("bp_flags_stable", 32'(flags), 32'(f0));
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_hs_out_valid", 32'(out_valid), 32'd0);
        check("post_hs_in_ready", 32'(in_ready), 32'd1);
        check("post_hs_res_hold", 32'(result), 32'(r0));
    endtask

    initial begin
        logic [11:0] m;
        logic [3:0]  ro;
        logic [7:0]  ra, rb;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = 8'h00; b = 8'h00; op = 4'h0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        rst_n = 1'b1;

        // Directed vectors: op, a, b, expected {N,V,C,Z}, expected result.
        do_op(4'd0,  8'h7F, 8'h01, 4'b1100, 8'h80, 0, 1'b0);
        do_op(4'd1,  8'h00, 8'h01, 4'b1000, 8'hFF, 0, 1'b0);
        do_op(4'd1,  8'h80, 8'h01, 4'b0110, 8'h7F, 0, 1'b0);
        do_op(4'd6,  8'hFF, 8'h01, 4'b0000, 8'h01, 0, 1'b0);
        do_op(4'd7,  8'h5A, 8'h5A, 4'b0000, 8'h01, 0, 1'b0);
        do_op(4'd11, 8'h90, 8'h03, 4'b1000, 8'hF2, 0, 1'b0);
        do_op(4'd8,  8'd13, 8'd11, 4'b1000, 8'h8F, 5, 1'b1);
        do_op(4'd8,  8'h10, 8'h10, 4'b0011, 8'h00, 0, 1'b0);
        do_op(4'd13, 8'hAB, 8'hCD, 4'b0001, 8'h00, 0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = 8'($urandom);
            rb = 8'($urandom);
            m  = model(ro, ra, rb);
            do_op(ro, ra, rb, m[11:8], m[7:0], int'($urandom_range(0, 2)), 1'b0);
        end

        do_op(4'd5, 8'h0F, 8'hF0, 4'b1000, 8'hFF, 0, 1'b0);

        // Abort a multiply with reset three cycles in.
        @(negedge clk);
        in_valid = 1'b1; op = 4'd8; a = 8'd7; b = 8'd9;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_flags", 32'(flags), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(4'd0, 8'd2, 8'd3, 4'b0000, 8'h05, 0, 1'b0);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked sequential ALU for the NPC datapath. It accepts one operation per transaction on a valid/ready input channel and computes it: single-cycle for logic/arithmetic/shift ops, iterative shift-add for multiply. It returns the result plus Z/C/V/N flags on a valid/ready output channel. It succeeds the fixed 4-bit combinational ALU, adding width parametrisation, status flags, a proper signed compare, shifts, multiply and backpressure.

## Interface
- WIDTH, 8: operand/result width in bits; ≥4, power of two.
- SHW, $clog2(WIDTH): shift-amount width (derived, not overridden).

- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  4  operation code.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  registered result.
- flags  out  4  registered {N,V,C,Z}, bit 3..0.

## Operation
- Ops, with operands treated as unsigned unless stated:
  - 0 ADD: a+b.
  - 1 SUB: a+~b+1.
  - 2 NOT: ~a.
  - 3 AND, 4 OR, 5 XOR.
  - 6 SLT: signed a<b gives 1, else 0, zero-extended.
  - 7 EQ: a==b gives 1, else 0.
  - 8 MUL: low WIDTH bits of a*b.
  - 9 SHL: a<<b[SHW-1:0].
  - 10 SRL: logical right shift by the same amount.
  - 11 SRA: arithmetic right shift by the same amount.
  - 12–15: result 0.
- Z = (result==0). N = result[WIDTH-1].
- C:
  - ADD/SUB: carry-out of the WIDTH-bit adder. For SUB, C=0 means borrow.
  - Shifts: last bit shifted out; 0 when the amount is 0.
  - MUL: 1 if any bit of the full 2·WIDTH-bit product above WIDTH-1 is nonzero.
  - Otherwise 0.
- V: signed overflow for ADD/SUB only, otherwise 0.
- FSM states:
  - IDLE → EXEC when in_valid & in_ready, for any op except MUL. Operands are latched.
  - IDLE → MUL when in_valid & in_ready and op==MUL. The multiplier is loaded.
  - EXEC → DONE after 1 cycle. result and flags are registered.
  - MUL → DONE after exactly WIDTH iteration cycles. result and flags are registered.
  - DONE → IDLE when out_ready.
- in_ready = (state==IDLE). out_valid = (state==DONE). No new request is accepted in the cycle DONE→IDLE.
- result and flags hold stable while out_valid & !out_ready. They stay stable after handshake until the next DONE.
- Inputs a, b and op are sampled only at acceptance. Later changes have no effect.

## Timing
- Reset (async assert, sync-safe deassert):
  - state=IDLE, result=0, flags=0.
  - out_valid=0, in_ready=1.
  - Multiplier accumulator, counter and operand regs = 0.
- Latency from the accept edge to out_valid high:
  - Non-MUL: 2 cycles (accept, EXEC, then DONE).
  - MUL: WIDTH+1 cycles.
- Throughput, with no backpressure:
  - Non-MUL: one op per 3 cycles.
  - MUL: one op per WIDTH+2 cycles.
- Backpressure: DONE persists indefinitely. in_ready stays 0.
- Reset mid-MUL or mid-DONE: operation abandoned, result discarded, outputs return to reset values immediately.
- Simultaneous in_valid while out_valid & out_ready: the request is ignored that cycle and must be held by the producer until in_ready.
- Shift amounts ≥WIDTH cannot occur; only SHW bits are used.

## Structure
- Package alu_pkg:
  - op_e enum (4-bit, values above).
  - state_e enum (IDLE, EXEC, MUL, DONE).
  - Flag bit-index constants FLAG_Z=0, FLAG_C=1, FLAG_V=2, FLAG_N=3.
- Sub-module alu_mul_iter (param WIDTH):
  - Inputs: start, a, b.
  - Outputs: done, prod_lo[WIDTH], prod_hi_nz.
  - Shift-add, one multiplier bit per cycle, internal counter.
  - Same clk/rst_n.
- Top: FSM, operand latch, combinational op unit, flag logic, output registers.

## Test plan
All scenarios use WIDTH=8.
- ADD a=8'h7F, b=8'h01 → result 8'h80, flags N=1 V=1 C=0 Z=0; out_valid 2 cycles after accept.
- SUB a=8'h00, b=8'h01 → 8'hFF, N=1 C=0 V=0; SUB 8'h80−8'h01 → 8'h7F, V=1 C=1.
- SLT a=8'hFF, b=8'h01 → 8'h01; EQ a=b=8'h5A → 8'h01 Z=0; SRA 8'h90 by 3 → 8'hF2, C=0.
- MUL 8'd13×8'd11 → 8'h8F, C=0, out_valid exactly 9 cycles after accept; MUL 8'h10×8'h10 → 8'h00, Z=1, C=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → result/flags stable, in_ready=0; in_valid pulsed meanwhile is not accepted.
- Deassert rst_n 3 cycles into a MUL → immediately in_ready=1, out_valid=0, result=0, flags=0; a following ADD 2+3 returns 8'h05.
